mb_writeback: RTL and testbench
===============================

MB_WRITEBACK -- requirements
Module: mb_writeback

Interface
REQ-001 FRAME_W, 1280, frame width in pixels.
REQ-002 FRAME_H, 720, frame height in pixels.
REQ-003 MB_W, 8, macroblock width in pixels.
REQ-004 MB_H, 8, macroblock height in pixels.
REQ-005 LANES, 4, pixels per write beat; must divide MB_W.
REQ-006 ADDR_W, 20, write address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 in_valid  in  1  block offered.
REQ-010 in_ready  out  1  block accepted on in_valid & in_ready.
REQ-011 mb_row  in  16  pixel row of the block's top-left pixel.
REQ-012 mb_col  in  16  pixel column of the block's top-left pixel.
REQ-013 mb_pix  in  MB_W*MB_H*8  signed 8-bit pixels; pixel (r,c) occupies slice index r*MB_W+c.
REQ-014 clip_en  in  1  sampled at accept; 1 = negative pixels written as 0, 0 = raw two's-complement byte.
REQ-015 wr_en  out  1  write beat valid.
REQ-016 wr_ready  in  1  memory accepts beat on wr_en & wr_ready.
REQ-017 wr_addr  out  ADDR_W  linear pixel address of lane 0.
REQ-018 wr_data  out  LANES*8  lane k in bits [8k+7:8k].
REQ-019 wr_mask  out  LANES  bit k = lane k in-frame.
REQ-020 busy  out  1  high in WRITE and DONE.
REQ-021 done  out  1  one-cycle pulse on block completion.
REQ-022 err  out  1  one-cycle pulse with done when the origin lies outside the frame.

Function
REQ-023 FSM states SHALL be IDLE, WRITE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-024 On accept, the block SHALL capture mb_pix, mb_row, mb_col and clip_en into internal registers and ignore later input changes.
REQ-025 On accept with mb_row>=FRAME_H or mb_col>=FRAME_W, the block SHALL go IDLE->DONE with no beats and pulse err with done.
REQ-026 Otherwise IDLE->WRITE; the first wr_en SHALL assert on the cycle after accept.
REQ-027 Beats SHALL run row-major: r = 0..MB_H-1 outer, b = 0..MB_W/LANES-1 inner; lane k covers column mb_col+b*LANES+k.
REQ-028 wr_addr SHALL equal (mb_row+r)*FRAME_W + mb_col + b*LANES, computed at ADDR_W bits without truncation for legal inputs.
REQ-029 wr_mask bit k SHALL be 1 iff mb_col+b*LANES+k < FRAME_W; wr_data lanes with mask 0 SHALL be 0.
REQ-030 Rows with mb_row+r >= FRAME_H, and beats with an all-zero mask, SHALL be skipped and consume no cycles.
REQ-031 wr_en, wr_addr, wr_data and wr_mask SHALL be held stable while wr_en & !wr_ready; the block SHALL advance one beat per handshake.
REQ-032 With wr_ready=1, the block SHALL issue issued-beat count beats on consecutive cycles with no bubbles.
REQ-033 After the last handshake the FSM SHALL enter DONE: done=1 for exactly one cycle, then IDLE with in_ready=1 on the following cycle.

Reset
REQ-034 While reset=0 at a rising edge, the FSM SHALL go to IDLE and in_ready, wr_en, wr_mask, wr_addr, wr_data, busy, done and err SHALL all be 0.
REQ-035 in_ready SHALL rise on the first rising edge with reset=1.
REQ-036 Reset asserted mid-WRITE SHALL abandon the block: no further beats and no done pulse.

Verification
REQ-037 Origin (0,0), wr_ready=1 -> 16 consecutive beats at addresses 0,4,1280,1284,...,8960,8964, mask 1111, done on the cycle after beat 16.
REQ-038 Origin (716,1278) -> 4 beats (rows 716-719) at addresses 917758, 919038, 920318, 921598, mask 0011, no err.
REQ-039 Origin (0,0), wr_ready toggling 1010... -> outputs stable during every stall, exactly 16 handshakes, data matches input in order.
REQ-040 Pixel value -5: clip_en=1 -> byte 0x00; clip_en=0 -> byte 0xFB.
REQ-041 Origin (720,0) -> no wr_en, done=err=1 on the cycle after accept, in_ready=1 on the cycle after that.
REQ-042 reset=0 during the 5th beat -> wr_en=0 after that edge, no done, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/mb_writeback.sv
// Macroblock writeback: streams a captured MB_W x MB_H pixel block into a
// linear frame buffer as LANES-wide write beats, clipping to the frame edges.
module mb_writeback #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int MB_W    = 8,
  parameter int MB_H    = 8,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              mb_row,
  input  logic [15:0]              mb_col,
  input  logic [MB_W*MB_H*8-1:0]   mb_pix,
  input  logic                     clip_en,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [LANES*8-1:0]       wr_data,
  output logic [LANES-1:0]         wr_mask,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int BPR = MB_W / LANES;
  localparam int B_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int R_W = (MB_H > 1) ? $clog2(MB_H) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   live;
  logic [MB_W*MB_H*8-1:0] pix_q;
  logic [15:0]            row_q, col_q;
  logic                   clip_q, err_q;
  logic [R_W-1:0]         r_q;
  logic [B_W-1:0]         b_q;
  logic                   accept, origin_out, hs, b_more, r_more;
  logic [7:0]             px;

  assign accept     = in_valid & in_ready;
  assign origin_out = ({1'b0, mb_row} >= 17'(FRAME_H)) || ({1'b0, mb_col} >= 17'(FRAME_W));
  assign hs         = wr_en & wr_ready;

  // Off-frame beats/rows only ever occur at the tail of a row/block, so
  // skipping reduces to "move on to the next row" or "finish".
  assign b_more = (b_q != B_W'(BPR - 1)) &&
                  ({1'b0, col_q} + 17'((32'(b_q) + 1) * LANES) < 17'(FRAME_W));
  assign r_more = (r_q != R_W'(MB_H - 1)) &&
                  ({1'b0, row_q} + 17'(r_q) + 17'd1 < 17'(FRAME_H));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = origin_out ? DONE : WRITE;
      WRITE:   if (hs && !b_more && !r_more) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q    <= '0;
      b_q    <= '0;
      err_q  <= 1'b0;
      clip_q <= 1'b0;
    end else if (accept) begin
      pix_q  <= mb_pix;
      row_q  <= mb_row;
      col_q  <= mb_col;
      clip_q <= clip_en;
      err_q  <= origin_out;
      r_q    <= '0;
      b_q    <= '0;
    end else if (hs) begin
      if (b_more) begin
        b_q <= b_q + B_W'(1);
      end else begin
        b_q <= '0;
        r_q <= r_q + R_W'(1);
      end
    end
  end

  always_comb begin
    in_ready = (state == IDLE) && live;
    wr_en    = (state == WRITE);
    busy     = (state == WRITE) || (state == DONE);
    done     = (state == DONE);
    err      = (state == DONE) && err_q;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    px       = '0;
    if (state == WRITE) begin
      wr_addr = (ADDR_W'(row_q) + ADDR_W'(r_q)) * ADDR_W'(FRAME_W)
              + ADDR_W'(col_q) + ADDR_W'(32'(b_q) * LANES);
      for (int unsigned k = 0; k < LANES; k++) begin
        if ({1'b0, col_q} + 17'(32'(b_q) * LANES + k) < 17'(FRAME_W)) begin
          wr_mask[k]       = 1'b1;
          px               = pix_q[(32'(r_q) * MB_W + 32'(b_q) * LANES + k) * 8 +: 8];
          wr_data[8*k +: 8] = (clip_q && px[7]) ? 8'h00 : px;
        end
      end
    end
  end

endmodule

// File: tb/tb_mb_writeback.sv
// Randomized self-checking bench for mb_writeback against a beat-list model
// enumerated directly from block origin, frame bounds and pixel data.
module tb_mb_writeback;

  localparam int FW   = 1280;
  localparam int FH   = 720;
  localparam int MBW  = 8;
  localparam int MBH  = 8;
  localparam int L    = 4;
  localparam int AW   = 20;
  localparam int PIXW = MBW * MBH * 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [15:0]     mb_row = '0;
  logic [15:0]     mb_col = '0;
  logic [PIXW-1:0] mb_pix = '0;
  logic            clip_en = 1'b0;
  logic            wr_en;
  logic            wr_ready = 1'b0;
  logic [AW-1:0]   wr_addr;
  logic [L*8-1:0]  wr_data;
  logic [L-1:0]    wr_mask;
  logic            busy, done, err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PIXW-1:0] blk_pix;
  logic [AW-1:0]   qa[$];
  logic [31:0]     qd[$];
  logic [3:0]      qm[$];
  int              dut_hs;
  logic [AW-1:0]   first_addr;
  logic [31:0]     first_data;
  logic [3:0]      first_mask;

  mb_writeback #(
    .FRAME_W(FW), .FRAME_H(FH), .MB_W(MBW), .MB_H(MBH), .LANES(L), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mb_row(mb_row), .mb_col(mb_col), .mb_pix(mb_pix), .clip_en(clip_en),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Expected beat list: every in-frame row of the block, every beat with at
  // least one in-frame lane, in row-major order.
  function automatic void build_model(input int row, input int col, input bit clip);
    qa.delete(); qd.delete(); qm.delete();
    for (int r = 0; r < MBH; r++) begin
      if (row + r >= FH) continue;
      for (int b = 0; b < MBW / L; b++) begin
        logic [3:0]  m;
        logic [31:0] d;
        logic [7:0]  p;
        m = '0;
        d = '0;
        for (int k = 0; k < L; k++) begin
          if (col + b * L + k < FW) begin
            m[k] = 1'b1;
            p = blk_pix[((r * MBW) + b * L + k) * 8 +: 8];
            d[k*8 +: 8] = (clip && $signed(p) < 0) ? 8'h00 : p;
          end
        end
        if (m != 0) begin
          qa.push_back(AW'((row + r) * FW + col + b * L));
          qd.push_back(d);
          qm.push_back(m);
        end
      end
    end
  endfunction

  task automatic randomize_pix();
    for (int i = 0; i < PIXW / 32; i++) blk_pix[i*32 +: 32] = $urandom();
  endtask

  // mode 0: wr_ready always 1, 1: toggling 1010..., 2: random
  task automatic run_block(input logic [15:0] row, input logic [15:0] col,
                           input bit clip, input int mode);
    bit exp_en, exp_err, rdy;
    build_model(row, col, clip);
    exp_err    = (row >= FH) || (col >= FW);
    dut_hs     = 0;
    first_addr = '0;
    first_data = '0;
    first_mask = '0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle row=%0d col=%0d got=%b exp=1", row, col, in_ready);
    end
    in_valid = 1'b1;
    mb_row   = row;
    mb_col   = col;
    mb_pix   = blk_pix;
    clip_en  = clip;
    wr_ready = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      mb_row   = 16'($urandom());
      mb_col   = 16'($urandom());
      clip_en  = ~clip;
      for (int i = 0; i < PIXW / 32; i++) mb_pix[i*32 +: 32] = $urandom();
      exp_en = (qa.size() > 0);
      n_cmp++;
      if (wr_en !== exp_en) begin
        n_fail++;
        $display("FAIL wr_en row=%0d col=%0d cyc=%0d got=%b exp=%b", row, col, cyc, wr_en, exp_en);
      end
      n_cmp++;
      if (done !== !exp_en) begin
        n_fail++;
        $display("FAIL done row=%0d col=%0d cyc=%0d got=%b exp=%b", row, col, cyc, done, !exp_en);
      end
      n_cmp++;
      if (err !== (!exp_en && exp_err)) begin
        n_fail++;
        $display("FAIL err row=%0d col=%0d cyc=%0d got=%b exp=%b", row, col, cyc, err, !exp_en && exp_err);
      end
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready row=%0d col=%0d cyc=%0d got busy=%b in_ready=%b exp busy=1 in_ready=0",
                 row, col, cyc, busy, in_ready);
      end
      if (exp_en) begin
        n_cmp++;
        if (wr_addr !== qa[0] || wr_data !== qd[0] || wr_mask !== qm[0]) begin
          n_fail++;
          $display("FAIL beat row=%0d col=%0d cyc=%0d got addr=%0d data=%h mask=%b exp addr=%0d data=%h mask=%b",
                   row, col, cyc, wr_addr, wr_data, wr_mask, qa[0], qd[0], qm[0]);
        end
      end
      if (wr_en === 1'b1 && dut_hs == 0) begin
        first_addr = wr_addr;
        first_data = wr_data;
        first_mask = wr_mask;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      wr_ready = rdy;
      if (wr_en === 1'b1 && rdy) dut_hs++;
      if (exp_en && rdy) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        void'(qm.pop_front());
      end
      if (!exp_en) break;
    end
    @(negedge clk);
    wr_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || done !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL return_idle row=%0d col=%0d got in_ready=%b done=%b wr_en=%b busy=%b exp 1 0 0 0",
               row, col, in_ready, done, wr_en, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, wr_en, busy, done, err} !== 5'b0 || wr_mask !== '0 ||
          wr_addr !== '0 || wr_data !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got rdy=%b en=%b busy=%b done=%b err=%b addr=%0d data=%h mask=%b exp all 0",
                 in_ready, wr_en, busy, done, err, wr_addr, wr_data, wr_mask);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_origin0();
    randomize_pix();
    run_block(16'd0, 16'd0, 1'($urandom_range(0, 1)), 0);
    n_cmp++;
    if (dut_hs != 16 || first_addr !== 20'd0 || first_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL origin0 got hs=%0d addr=%0d mask=%b exp hs=16 addr=0 mask=1111",
               dut_hs, first_addr, first_mask);
    end
  endtask

  task automatic test_border();
    randomize_pix();
    run_block(16'd716, 16'd1278, 1'b0, 0);
    n_cmp++;
    if (dut_hs != 4 || first_addr !== 20'd917758 || first_mask !== 4'b0011) begin
      n_fail++;
      $display("FAIL border got hs=%0d addr=%0d mask=%b exp hs=4 addr=917758 mask=0011",
               dut_hs, first_addr, first_mask);
    end
  endtask

  task automatic test_stall();
    randomize_pix();
    run_block(16'd0, 16'd0, 1'b0, 1);
    n_cmp++;
    if (dut_hs != 16) begin
      n_fail++;
      $display("FAIL stall_handshakes got=%0d exp=16", dut_hs);
    end
  endtask

  task automatic test_clip();
    for (int i = 0; i < MBW * MBH; i++) blk_pix[i*8 +: 8] = 8'hFB;
    run_block(16'd0, 16'd0, 1'b1, 0);
    n_cmp++;
    if (first_data !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL clip_on got=%h exp=00000000", first_data);
    end
    run_block(16'd0, 16'd0, 1'b0, 0);
    n_cmp++;
    if (first_data !== 32'hFBFB_FBFB) begin
      n_fail++;
      $display("FAIL clip_off got=%h exp=fbfbfbfb", first_data);
    end
  endtask

  task automatic test_out_of_frame();
    randomize_pix();
    run_block(16'd720, 16'd0, 1'b0, 0);
    run_block(16'd0, 16'd1280, 1'b1, 0);
    n_cmp++;
    if (dut_hs != 0) begin
      n_fail++;
      $display("FAIL oof_beats got=%0d exp=0", dut_hs);
    end
  endtask

  task automatic test_random();
    logic [15:0] row, col;
    for (int n = 0; n < 30; n++) begin
      randomize_pix();
      case ($urandom_range(0, 3))
        0: begin row = 16'($urandom_range(0, FH - 1)); col = 16'($urandom_range(0, FW - 1)); end
        1: begin row = 16'(FH - 1 - $urandom_range(0, 8)); col = 16'(FW - 1 - $urandom_range(0, 8)); end
        2: begin
          if ($urandom_range(0, 1) == 1) begin
            row = 16'(FH + $urandom_range(0, 100)); col = 16'($urandom_range(0, FW - 1));
          end else begin
            row = 16'($urandom_range(0, FH - 1)); col = 16'(FW + $urandom_range(0, 100));
          end
        end
        default: begin row = 16'($urandom_range(0, 89) * 8); col = 16'($urandom_range(0, 159) * 8); end
      endcase
      run_block(row, col, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_abort();
    randomize_pix();
    build_model(0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    mb_row   = '0;
    mb_col   = '0;
    mb_pix   = blk_pix;
    clip_en  = 1'b0;
    wr_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== qa[0]) begin
        n_fail++;
        $display("FAIL abort_beat%0d got en=%b addr=%0d exp en=1 addr=%0d", i, wr_en, wr_addr, qa[0]);
      end
      void'(qa.pop_front());
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset got en=%b done=%b busy=%b rdy=%b exp 0 0 0 0", wr_en, done, busy, in_ready);
    end
    reset = 1'b1;
    wr_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release got rdy=%b en=%b done=%b exp 1 0 0", in_ready, wr_en, done);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet got done=%b en=%b exp 0 0", done, wr_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_origin0();
    test_border();
    test_stall();
    test_clip();
    test_out_of_frame();
    test_random();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
